// File: rtl/video_sig_gen_pkg.sv
// Shared 720p60 timing defaults, width/total helpers and the sync bundle type
// for the video_sig_gen raster generator.
package video_timing_pkg;

  localparam int DEF_ACTIVE_H_PIXELS = 1280;
  localparam int DEF_H_FRONT_PORCH   = 110;
  localparam int DEF_H_SYNC_WIDTH    = 40;
  localparam int DEF_H_BACK_PORCH    = 220;
  localparam int DEF_ACTIVE_LINES    = 720;
  localparam int DEF_V_FRONT_PORCH   = 5;
  localparam int DEF_V_SYNC_WIDTH    = 5;
  localparam int DEF_V_BACK_PORCH    = 20;
  localparam int DEF_FPS             = 60;

  function automatic int total4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  // Keeps a degenerate modulus of 1 from producing a zero-width vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_H_TOTAL = total4(DEF_ACTIVE_H_PIXELS, DEF_H_FRONT_PORCH,
                                      DEF_H_SYNC_WIDTH, DEF_H_BACK_PORCH);
  localparam int DEF_V_TOTAL = total4(DEF_ACTIVE_LINES, DEF_V_FRONT_PORCH,
                                      DEF_V_SYNC_WIDTH, DEF_V_BACK_PORCH);

  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_t;

endpackage

// File: rtl/video_sig_gen_wrap_counter.sv
// Modulo-MAX counter advanced by inc_in; resets to MAX-1 so the first
// increment after reset lands on 0. wrap_out flags the MAX-1 -> 0 step.
module wrap_counter
  import video_timing_pkg::*;
#(
  parameter int MAX = 16,
  localparam int W = cnt_width(MAX)
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         inc_in,
  output logic [W-1:0] count_out,
  output logic         wrap_out
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign wrap_out = inc_in && (count_q == W'(MAX - 1));
  assign count_d  = wrap_out ? '0 : count_q + W'(1);

  // NOTE: state registers take non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      count_q <= W'(MAX - 1);
    else if (inc_in) count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator (720p60 default) with registered,
// mutually aligned outputs. Frame counter enabled by VIDEO_SIG_GEN_FRAME_COUNT_EN.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter int FPS             = DEF_FPS,
  localparam int H_TOTAL = total4(ACTIVE_H_PIXELS, H_FRONT_PORCH, H_SYNC_WIDTH, H_BACK_PORCH),
  localparam int V_TOTAL = total4(ACTIVE_LINES, V_FRONT_PORCH, V_SYNC_WIDTH, V_BACK_PORCH),
  localparam int HW = cnt_width(H_TOTAL),
  localparam int VW = cnt_width(V_TOTAL),
  localparam int FW = cnt_width(FPS)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [FW-1:0] fc_out
);

  // Inclusive decode bounds; all strictly below the totals so they fit the counter widths.
  localparam logic [HW-1:0] HS_FIRST = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
  localparam logic [HW-1:0] HS_LAST  = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [HW-1:0] AD_H_END = HW'(ACTIVE_H_PIXELS - 1);
  localparam logic [HW-1:0] NF_H     = HW'(ACTIVE_H_PIXELS);
  localparam logic [VW-1:0] VS_FIRST = VW'(ACTIVE_LINES + V_FRONT_PORCH);
  localparam logic [VW-1:0] VS_LAST  = VW'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  localparam logic [VW-1:0] AD_V_END = VW'(ACTIVE_LINES - 1);
  localparam logic [VW-1:0] NF_V     = VW'(ACTIVE_LINES);

  logic [HW-1:0] h_pos, h_next, hcount_q;
  logic [VW-1:0] v_pos, v_next, vcount_q;
  logic          h_wrap, v_wrap;
  sync_t         sync_d, sync_q;
  logic          nf_d, nf_q;

  wrap_counter #(.MAX(H_TOTAL)) u_pixel_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (1'b1),
    .count_out (h_pos),
    .wrap_out  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL)) u_line_cnt (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .inc_in    (h_wrap),
    .count_out (v_pos),
    .wrap_out  (v_wrap)
  );

  // Decode the position the counters move to on this edge so the registered
  // flags line up with the registered coordinates.
  always_comb begin
    h_next = h_wrap ? '0 : h_pos + HW'(1);
    v_next = v_pos;
    if (h_wrap) v_next = v_wrap ? '0 : v_pos + VW'(1);
    sync_d.hs = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
    sync_d.vs = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    sync_d.ad = (h_next <= AD_H_END) && (v_next <= AD_V_END);
    nf_d      = (h_next == NF_H) && (v_next == NF_V);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hcount_q <= '0;
      vcount_q <= '0;
      sync_q   <= '0;
      nf_q     <= 1'b0;
    end else begin
      hcount_q <= h_next;
      vcount_q <= v_next;
      sync_q   <= sync_d;
      nf_q     <= nf_d;
    end
  end

`ifdef VIDEO_SIG_GEN_FRAME_COUNT_EN
  logic [FW-1:0] fc_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)    fc_q <= '0;
    else if (nf_q) fc_q <= (fc_q == FW'(FPS - 1)) ? '0 : fc_q + FW'(1);
  end

  assign fc_out = fc_q;
`else
  assign fc_out = '0;
`endif

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = sync_q.hs;
  assign vs_out     = sync_q.vs;
  assign ad_out     = sync_q.ad;
  assign nf_out     = nf_q;

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
Free-running raster timing generator that feeds the three TMDS channel encoders in the HDMI output path.
- Produces pixel coordinates, horizontal/vertical sync, active-draw enable and a new-frame strobe.
- The pixel/pattern logic consumes hcount/vcount to produce RGB. ad_out drives the encoders' video-enable. {vs_out,hs_out} drives the blue channel's control input.
- Default timing is 1280x720@60 (74.25 MHz pixel clock), positive-polarity syncs.

Parameters:
ACTIVE_H_PIXELS, 1280, visible pixels per line
H_FRONT_PORCH, 110, pixels between active end and hsync start
H_SYNC_WIDTH, 40, hsync pulse width in pixels
H_BACK_PORCH, 220, pixels between hsync end and next line
ACTIVE_LINES, 720, visible lines per frame
V_FRONT_PORCH, 5, lines between active end and vsync start
V_SYNC_WIDTH, 5, vsync pulse width in lines
V_BACK_PORCH, 20, lines between vsync end and next frame
FPS, 60, frame-counter modulus

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous, active-high reset
hcount_out  output  $clog2(H_TOTAL)  current pixel column (11 bits default)
vcount_out  output  $clog2(V_TOTAL)  current line (10 bits default)
hs_out  output  1  horizontal sync, active high
vs_out  output  1  vertical sync, active high
ad_out  output  1  active draw (pixel inside visible region)
nf_out  output  1  new-frame strobe, one cycle
fc_out  output  $clog2(FPS)  frame counter (6 bits default)

Behaviour:
Timing totals:
- H_TOTAL = sum of the four H parameters (1650 default).
- V_TOTAL = sum of the four V parameters (750 default).

Reset:
- Asynchronous. While rst_in=1, all outputs are 0.
- Internal position is forced to (H_TOTAL-1, V_TOTAL-1), so the first clock edge after deassertion presents pixel (0,0) with ad_out=1.

Counting:
- Every edge, hcount advances by 1.
- At hcount=H_TOTAL-1 it wraps to 0 and vcount advances.
- At vcount=V_TOTAL-1 with hcount=H_TOTAL-1, both wrap to 0.
- There is no enable and no stall.

Output decoding:
- All outputs are registered and mutually aligned: hs/vs/ad/nf/fc describe the same pixel as hcount_out/vcount_out in that cycle. Decode from the next position, then register.
- hs_out=1 iff ACTIVE_H_PIXELS+H_FRONT_PORCH <= hcount < that bound +H_SYNC_WIDTH. Default range is 1390..1429.
- vs_out=1 iff ACTIVE_LINES+V_FRONT_PORCH <= vcount < that bound +V_SYNC_WIDTH. Default range is 725..729, for every hcount in those lines.
- ad_out=1 iff hcount<ACTIVE_H_PIXELS and vcount<ACTIVE_LINES.
- nf_out=1 only on pixel (ACTIVE_H_PIXELS, ACTIVE_LINES), i.e. (1280,720): exactly one cycle per frame.

Width and arithmetic rules:
- Comparisons are unsigned.
- Counter widths come from $clog2 of the totals. Counters never exceed total-1.

Reset mid-frame:
- Outputs go to 0 immediately (asynchronous).
- Restart is at (0,0) as above; no partial-frame strobes.

Optional Feature:
Macro: VIDEO_SIG_GEN_FRAME_COUNT_EN
- Defined: fc_out increments in the cycle after nf_out=1 (the cycle showing (1281,720)). It wraps from FPS-1 to 0 and is reset to 0.
- Undefined: fc_out is constant 0 and no counter logic is synthesized. The port remains so instantiations are unchanged.

Decomposition:
Package video_timing_pkg holds:
- the 720p default constants;
- localparam helpers for H_TOTAL/V_TOTAL;
- a typedef struct for the sync bundle {hs, vs, ad}.

Sub-module wrap_counter is used twice (pixel and line):
- parameters MAX;
- ports clk_in, rst_in, inc_in, count_out, wrap_out;
- wrap_out is high when count=MAX-1 and inc_in=1.

Test Plan:
- Reset release: hold rst_in 5 cycles, deassert -> first edge hcount=0, vcount=0, ad=1, hs=vs=nf=0; all outputs 0 during reset.
- Line timing: run one line -> ad high for 1280 cycles, hs high exactly for hcount 1390..1429 (40 cycles), hcount wraps 1649->0 with vcount 0->1.
- Frame timing: run one frame (1,237,500 cycles) -> vs high for hcount 0..1649 of lines 725..729 (8250 cycles); ad=0 for all vcount>=720; vcount wraps 749->0.
- New-frame strobe: over 3 frames -> nf pulses exactly 3 times, each at (1280,720), spaced 1,237,500 cycles.
- Frame counter (macro defined): run 61 frames -> fc counts 0..59, wraps to 0 after 60th nf, reads 1 after 61st. Macro undefined -> fc stays 0.
- Mid-frame reset: assert rst_in asynchronously at (600,300) between edges -> outputs 0 before next edge; after release restart at (0,0), no nf before (1280,720).
